// File: rtl/falu_issue_ctrl.sv
// Issue controller for a multi-cycle FPU: one op in flight, start pulse, wait for done, watchdog abort.
// Latency: start at accept+1, result valid at done+1; in_ready only in IDLE, result held until out_ready.
module falu_issue_ctrl #(
  parameter int          TAG_W   = 5,
  parameter int          NUM_OPS = 5,
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             fpu_clk_en,
  output logic             fpu_start,
  output logic [2:0]       fpu_n,
  output logic [31:0]      fpu_dataa,
  output logic [31:0]      fpu_datab,
  output logic             fpu_reset,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int             CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECOVER,
    S_HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic             timeout_hit;

  assign legal       = (32'(in_mode) < NUM_OPS);
  assign timeout_hit = (cnt == CNT_MAX);

  assign in_ready   = (state == S_IDLE);
  assign fpu_start  = (state == S_ISSUE);
  assign fpu_clk_en = (state == S_ISSUE) || (state == S_WAIT) || (state == S_RECOVER);
  // The FPU is held in reset for as long as the controller itself is.
  assign fpu_reset  = !rst_n || (state == S_RECOVER);
  assign out_valid  = (state == S_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (in_valid) state_nxt = legal ? S_ISSUE : S_HOLD;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (fpu_done)         state_nxt = S_HOLD;
        else if (timeout_hit) state_nxt = S_RECOVER;
      end
      S_RECOVER: state_nxt = S_HOLD;
      S_HOLD:    if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      fpu_n      <= '0;
      fpu_dataa  <= '0;
      fpu_datab  <= '0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            out_tag <= in_tag;
            // Illegal ops never touch the FPU-facing operand registers.
            if (legal) begin
              fpu_n     <= in_mode;
              fpu_dataa <= in_a;
              fpu_datab <= in_b;
            end else begin
              out_result <= NAN_VAL;
              out_err    <= 1'b1;
            end
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (fpu_done) begin
            out_result <= fpu_result;
            out_err    <= 1'b0;
          end else if (timeout_hit) begin
            out_result <= NAN_VAL;
            out_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
